// File: rtl/fifo_wr_bank_16.sv
// Write-side storage bank for the 16-deep FIFOs: entry array, wrap-tagged pointers, flags.
// Optional sticky overflow/underflow flag o_err when FIFO_WR_BANK_ERR_EN is defined.
module fifo_wr_bank_16 #(
   parameter int bw   = 4,
   parameter int simd = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [simd*bw-1:0]       in,
   input  logic                     wr,
   input  logic                     rd,
   output logic [16*simd*bw-1:0]    q_all,
   output logic [3:0]               rd_sel,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [4:0]               count
`ifdef FIFO_WR_BANK_ERR_EN
   ,
   output logic                     o_err
`endif
);

   localparam int W = simd * bw;

   logic [W-1:0] mem [16];
   logic [4:0]   wr_ptr;
   logic [4:0]   rd_ptr;
   logic         push;
   logic         pop;

   // Bit 4 is the wrap tag: equal index with differing tags means full.
   assign o_empty = (wr_ptr == rd_ptr);
   assign o_full  = (wr_ptr[3:0] == rd_ptr[3:0]) & (wr_ptr[4] != rd_ptr[4]);
   assign count   = wr_ptr - rd_ptr;
   assign rd_sel  = rd_ptr[3:0];

   assign push = wr & ~o_full;
   assign pop  = rd & ~o_empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int k = 0; k < 16; k++) begin
            mem[k] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr[3:0]] <= in;
            wr_ptr           <= wr_ptr + 5'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 5'd1;
         end
      end
   end

   for (genvar g = 0; g < 16; g++) begin : g_flat
      assign q_all[g*W +: W] = mem[g];
   end

`ifdef FIFO_WR_BANK_ERR_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_err <= 1'b0;
      end else if ((wr & o_full) | (rd & o_empty)) begin
         o_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_wr_bank_16.sv
// Randomised self-checking bench for fifo_wr_bank_16 against a count-based FIFO model.
// Checks o_err as well when FIFO_WR_BANK_ERR_EN is defined.
module tb_fifo_wr_bank_16;

   localparam int BW = 4;
   localparam int SIMD = 8;
   localparam int W = BW * SIMD;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [W-1:0]    in = '0;
   logic            wr = 1'b0;
   logic            rd = 1'b0;
   logic [16*W-1:0] q_all;
   logic [3:0]      rd_sel;
   logic            o_full;
   logic            o_empty;
   logic [4:0]      count;
`ifdef FIFO_WR_BANK_ERR_EN
   logic            o_err;
`endif

   int total = 0;
   int bad = 0;

   // Model: storage slots plus unbounded push/pop totals.
   logic [W-1:0] m_ent [16];
   int           m_wn;
   int           m_rn;
   bit           m_err;

   fifo_wr_bank_16 #(.bw(BW), .simd(SIMD)) dut (
      .clk     (clk),
      .reset   (reset),
      .in      (in),
      .wr      (wr),
      .rd      (rd),
      .q_all   (q_all),
      .rd_sel  (rd_sel),
      .o_full  (o_full),
      .o_empty (o_empty),
      .count   (count)
`ifdef FIFO_WR_BANK_ERR_EN
      ,
      .o_err   (o_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] obs,
                      input logic [511:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [16*W-1:0] m_flat();
      logic [16*W-1:0] f;
      for (int k = 0; k < 16; k++) f[k*W +: W] = m_ent[k];
      return f;
   endfunction

   task automatic m_clear();
      for (int k = 0; k < 16; k++) m_ent[k] = '0;
      m_wn = 0;
      m_rn = 0;
      m_err = 0;
   endtask

   task automatic check_all(input string tag);
      int n;
      n = m_wn - m_rn;
      chk({tag, ".count"}, 512'(count), 512'(n));
      chk({tag, ".full"}, 512'(o_full), 512'(n == 16));
      chk({tag, ".empty"}, 512'(o_empty), 512'(n == 0));
      chk({tag, ".rd_sel"}, 512'(rd_sel), 512'(m_rn % 16));
      chk({tag, ".q_all"}, 512'(q_all), 512'(m_flat()));
`ifdef FIFO_WR_BANK_ERR_EN
      chk({tag, ".err"}, 512'(o_err), 512'(m_err));
`endif
   endtask

   // Called #1 after an edge; applies one cycle and checks after the next edge.
   task automatic cycle(input bit w, input bit r, input logic [W-1:0] d,
                        input string tag);
      int n;
      wr = w;
      rd = r;
      in = d;
      @(posedge clk);
      n = m_wn - m_rn;
      if ((w && n == 16) || (r && n == 0)) m_err = 1;
      if (w && n < 16) begin
         m_ent[m_wn % 16] = d;
         m_wn++;
      end
      if (r && n > 0) m_rn++;
      #1;
      check_all(tag);
   endtask

   // Asserts reset mid-cycle and checks the asynchronous clear before the next edge.
   task automatic do_reset(input string tag);
      wr = 0;
      rd = 0;
      #2;
      reset = 1'b1;
      #1;
      m_clear();
      check_all(tag);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      m_clear();
      #2;
      check_all("reset_async");
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_all("reset");

      for (int k = 0; k < 16; k++) cycle(1, 0, 32'h11111111 * k, "fill");
      chk("fill16.count", 512'(count), 512'(16));
      chk("fill16.full", 512'(o_full), 512'(1));
      chk("fill16.e5", 512'(q_all[5*W +: W]), 512'(32'h55555555));

      cycle(1, 0, 32'hDEADBEEF, "push_full");

      for (int k = 0; k < 16; k++) cycle(0, 1, '0, "drain");
      chk("drain.empty", 512'(o_empty), 512'(1));
      cycle(0, 1, '0, "pop_empty");

      do_reset("rst1");
      for (int k = 0; k < 10; k++) cycle(1, 0, $urandom, "p10a");
      for (int k = 0; k < 10; k++) cycle(0, 1, '0, "pop10");
      for (int k = 0; k < 10; k++) cycle(1, 0, 32'hA0000000 + k, "p10b");
      chk("wrap.e15", 512'(q_all[15*W +: W]), 512'(32'hA0000005));
      chk("wrap.e3", 512'(q_all[3*W +: W]), 512'(32'hA0000009));

      do_reset("rst2");
      cycle(1, 1, 32'h0BADF00D, "both_empty");
      chk("both_empty.cnt1", 512'(count), 512'(1));
      for (int k = 0; k < 15; k++) cycle(1, 0, $urandom, "fill2");
      cycle(1, 1, 32'hCAFEF00D, "both_full");
      chk("both_full.cnt15", 512'(count), 512'(15));
      for (int k = 0; k < 10; k++) cycle(0, 1, '0, "to5");
      cycle(1, 1, 32'h12345678, "both_mid");
      chk("both_mid.cnt5", 512'(count), 512'(5));

      for (int k = 0; k < 400; k++) begin
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom, "rand");
      end

      do_reset("rst3");
      for (int k = 0; k < 7; k++) cycle(1, 0, $urandom | 32'h1, "p7");
      chk("p7.count", 512'(count), 512'(7));
      do_reset("rst_mid7");
      cycle(0, 0, '0, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_wr_bank_16.md
# fifo_wr_bank_16

Write-side storage bank for the 16-deep activation/weight FIFOs in the core datapath. It captures `simd`-lane words into a 16-entry register array under a write strobe and advances a wrap-tagged write pointer. It exposes all 16 entries plus a read-select index that drives the 16:1 FIFO read multiplexer, and tracks the consumer's pops to produce full, empty and occupancy.

## Interface
Parameters:
- bw, 4, bits per lane
- simd, 8, lanes per word; word width W = simd*bw

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in  input  W  write data word
- wr  input  1  push request; accepted only when o_full=0
- rd  input  1  pop request from reader; accepted only when o_empty=0
- q_all  output  16*W  flattened entry array; entry k at bits [(k+1)*W-1 : k*W]
- rd_sel  output  4  index of the oldest valid entry; drives the 16:1 read-mux select
- o_full  output  1  16 entries valid
- o_empty  output  1  0 entries valid
- count  output  5  occupancy, 0..16
- o_err  output  1  sticky overflow/underflow flag; present only with FIFO_WR_BANK_ERR_EN

## Operation
- State: wr_ptr[4:0] and rd_ptr[4:0]. Bit 4 is the wrap tag, bits [3:0] are the index. Plus the 16×W entry registers.
- Push accepted (wr & ~o_full): entry[wr_ptr[3:0]] <= in; wr_ptr <= wr_ptr+1 (mod 32).
- Pop accepted (rd & ~o_empty): rd_ptr <= rd_ptr+1 (mod 32). Entry contents are not cleared.
- o_empty = (wr_ptr == rd_ptr).
- o_full = (wr_ptr[3:0] == rd_ptr[3:0]) & (wr_ptr[4] != rd_ptr[4]).
- count = wr_ptr - rd_ptr, as a 5-bit modular difference.
- rd_sel = rd_ptr[3:0].
- o_full, o_empty, count and rd_sel are combinational from the pointer registers only. No input-to-output combinational path.
- Rejected push (wr while o_full=1): word dropped, no state change.
- Rejected pop (rd while o_empty=1): ignored, no state change.
- Simultaneous wr & rd:
  - Acceptance is judged on the flags at the start of the cycle.
  - Neither full nor empty: both accepted, count unchanged.
  - Full: pop accepted, push dropped, count becomes 15.
  - Empty: push accepted, pop ignored, count becomes 1.
- Wrap-around: index 15 → 0 toggles bit 4. All 16 entries are usable.

## Timing
- Reset (async assert, sync release at next edge):
  - wr_ptr=0, rd_ptr=0, all entries=0.
  - o_empty=1, o_full=0, count=0, rd_sel=0, o_err=0.
- Reset asserted mid-operation discards all contents immediately. No pending push or pop completes.
- Write latency: a word pushed at edge N appears in q_all and is selectable via rd_sel after edge N. o_empty falls after edge N.
- Pop latency: rd_sel advances after the accepting edge. The reader samples the mux output in the same cycle it asserts rd.
- Throughput: one push and one pop per cycle, sustained.

## Configuration
- FIFO_WR_BANK_ERR_EN defined:
  - o_err port exists.
  - o_err sets at the edge where wr & o_full or rd & o_empty is sampled.
  - It holds until reset.
- Not defined: o_err port and its logic are absent. Dropped pushes and ignored pops are silent.

## Test plan
- Reset, then push 16 words 0x11111111·k (k=0..15) with no pops → count=16, o_full=1 after the 16th edge, entry k = pushed word k, rd_sel=0.
- From full, push 0xDEADBEEF → contents and pointers unchanged, count=16. With FIFO_WR_BANK_ERR_EN, o_err=1 next cycle.
- Pop 16 times from full → rd_sel steps 0..15 then wraps to 0, o_empty=1, count=0. A further pop changes nothing, and o_err=1 if enabled.
- Push 10, pop 10, then push 10 more → the writes wrap past index 15, and entries 10..15,0..3 hold the new words in order with wr_ptr[4]=1.
- Simultaneous wr & rd at empty, full, and count=5 → count becomes 1, 15, and 5 respectively.
- Assert reset asynchronously mid-cycle at count=7 → outputs change before the next clk edge to o_empty=1, count=0, q_all=0.
